// File: rtl/demux2_4_buf_pkg.sv
// Shared constants and types for the buffered 1:2 demux.
// Imported by the interface, buffer and top level.
package demux_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W     = 8;
  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/demux2_4_buf_if.sv
// Input and dual-output handshake bundle of the buffered demux.
// master drives words in and consumes outputs; slave is the block.
interface demux2_4_buf_if
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a_data;
  logic             out_a_valid;
  logic             out_a_ready;
  logic [WIDTH-1:0] out_b_data;
  logic             out_b_valid;
  logic             out_b_ready;
  cnt_t             cnt_a;
  cnt_t             cnt_b;

  modport master (
    output in_data, in_s, in_valid,
    input  in_ready,
    input  out_a_data, out_a_valid,
    output out_a_ready,
    input  out_b_data, out_b_valid,
    output out_b_ready,
    input  cnt_a, cnt_b
  );

  modport slave (
    input  in_data, in_s, in_valid,
    output in_ready,
    output out_a_data, out_a_valid,
    input  out_a_ready,
    output out_b_data, out_b_valid,
    input  out_b_ready,
    output cnt_a, cnt_b
  );
endinterface

// File: rtl/demux2_4_buf_fifo.sv
// Per-channel FIFO: registered storage, head word read straight
// from storage so there is no input-to-output combinational path.
module fifo_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap naturally
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push_ok) mem_q[wr_q] <= data_i;
    end
  end
endmodule

// File: rtl/demux2_4_buf.sv
// Buffered 1:2 demux: steers each accepted word to channel A or B
// by in_s and counts words delivered on each channel.
module demux2_4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  demux2_4_buf_if.slave    bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel_a, sel_b;
  logic          push_a, push_b;
  logic          pop_a, pop_b;
  logic          full_a, full_b;
  logic          empty_a, empty_b;
  logic [CW-1:0] count_a, count_b;
  cnt_t          cnt_a_q, cnt_a_d;
  cnt_t          cnt_b_q, cnt_b_d;

  assign sel_a = (bus.in_s == SEL_A);
  assign sel_b = (bus.in_s == SEL_B);

  // Readiness looks only at the selected buffer; no full-case bypass
  assign bus.in_ready = rst_n & (sel_b ? ~full_b : ~full_a);

  assign push_a = bus.in_valid & bus.in_ready & sel_a;
  assign push_b = bus.in_valid & bus.in_ready & sel_b;
  assign pop_a  = bus.out_a_ready & ~empty_a;
  assign pop_b  = bus.out_b_ready & ~empty_b;

  assign bus.out_a_valid = (count_a != '0);
  assign bus.out_b_valid = (count_b != '0);

  fifo_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_a),
    .data_i  (bus.in_data),
    .pop_i   (pop_a),
    .data_o  (bus.out_a_data),
    .count_o (count_a),
    .full_o  (full_a),
    .empty_o (empty_a)
  );

  fifo_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_b),
    .data_i  (bus.in_data),
    .pop_i   (pop_b),
    .data_o  (bus.out_b_data),
    .count_o (count_b),
    .full_o  (full_b),
    .empty_o (empty_b)
  );

  assign cnt_a_d = pop_a ? cnt_a_q + cnt_t'(1) : cnt_a_q;
  assign cnt_b_d = pop_b ? cnt_b_q + cnt_t'(1) : cnt_b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
endmodule

// File: tb/tb_demux2_4_buf.sv
// Directed-vector bench for demux2_4_buf with a queue scoreboard
// checked by a negedge monitor on both output channels.
module tb_demux2_4_buf;
  import demux_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   errs = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  demux2_4_buf_if #(.WIDTH(W)) bus ();

  demux2_4_buf #(
    .WIDTH (W),
    .DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs are stable at negedge, so what is
  // seen here is exactly what transfers on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (bus.out_a_valid) begin
        if (qa.size() == 0) chk("a_unexpected", 1, 0);
        else begin
          chk("a_data", 32'(bus.out_a_data), 32'(qa[0]));
          if (bus.out_a_ready) void'(qa.pop_front());
        end
      end
      if (bus.out_b_valid) begin
        if (qb.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          chk("b_data", 32'(bus.out_b_data), 32'(qb[0]));
          if (bus.out_b_ready) void'(qb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_s == SEL_A) qa.push_back(bus.in_data);
        else                   qb.push_back(bus.in_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_data     = 4'h5;
    bus.in_s        = SEL_A;
    bus.in_valid    = 1'b1;
    bus.out_a_ready = 1'b1;
    bus.out_b_ready = 1'b1;

    // Reset with in_valid held high
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_a_valid", 32'(bus.out_a_valid), 0);
    chk("rst_b_valid", 32'(bus.out_b_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_a_data", 32'(bus.out_a_data), 0);
    chk("rst_b_data", 32'(bus.out_b_data), 0);
    chk("rst_cnt_a", 32'(bus.cnt_a), 0);
    chk("rst_cnt_b", 32'(bus.cnt_b), 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ready_s0", 32'(bus.in_ready), 1);
    bus.in_s = SEL_B;
    #1;
    chk("rel_ready_s1", 32'(bus.in_ready), 1);

    // Routing
    bus.in_valid = 1'b1;
    bus.in_s     = SEL_A;
    bus.in_data  = 4'b0000;
    cyc();
    chk("rt_a_valid", 32'(bus.out_a_valid), 1);
    chk("rt_a_data", 32'(bus.out_a_data), 32'h0);
    chk("rt_b_idle", 32'(bus.out_b_valid), 0);
    bus.in_s    = SEL_B;
    bus.in_data = 4'b1010;
    cyc();
    chk("rt_b_valid", 32'(bus.out_b_valid), 1);
    chk("rt_b_data", 32'(bus.out_b_data), 32'hA);
    bus.in_valid = 1'b0;
    cyc();
    chk("rt_cnt_a", 32'(bus.cnt_a), 1);
    chk("rt_cnt_b", 32'(bus.cnt_b), 1);

    // Full / backpressure on A
    bus.out_a_ready = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_s        = SEL_A;
    bus.in_data     = 4'b1111;
    cyc();
    bus.in_data = 4'b1100;
    cyc();
    bus.in_data = 4'b0111;
    #1;
    chk("full_ready_s0", 32'(bus.in_ready), 0);
    bus.in_s = SEL_B;
    #1;
    chk("full_ready_s1", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    bus.in_s     = SEL_A;
    cyc();
    chk("full_hold", 32'(bus.out_a_data), 32'hF);
    bus.out_a_ready = 1'b1;
    cyc();
    cyc();
    chk("full_drained", 32'(bus.out_a_valid), 0);
    chk("full_cnt_a", 32'(bus.cnt_a), 3);

    // Simultaneous push and pop on A
    bus.out_a_ready = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_s        = SEL_A;
    bus.in_data     = 4'b0010;
    cyc();
    bus.out_a_ready = 1'b1;
    bus.in_data     = 4'b0011;
    cyc();
    chk("sim_valid", 32'(bus.out_a_valid), 1);
    chk("sim_head", 32'(bus.out_a_data), 32'h3);
    bus.in_valid = 1'b0;
    cyc();
    chk("sim_empty", 32'(bus.out_a_valid), 0);
    chk("sim_cnt_a", 32'(bus.cnt_a), 5);

    // Pointer and counter wrap on B
    do_reset();
    bus.out_b_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1;
      bus.in_s     = SEL_B;
      bus.in_data  = W'(i % 16);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc();
    cyc();
    chk("wrap_cnt_b", 32'(bus.cnt_b), 44);
    chk("wrap_b_empty", 32'(bus.out_b_valid), 0);

    // Mid-operation reset
    bus.out_a_ready = 1'b0;
    bus.out_b_ready = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_s        = SEL_A;
    bus.in_data     = 4'h9;
    cyc();
    bus.in_data = 4'h6;
    cyc();
    bus.in_s    = SEL_B;
    bus.in_data = 4'hD;
    cyc();
    bus.in_valid = 1'b0;
    chk("mid_a_full", 32'(bus.out_a_valid), 1);
    chk("mid_b_one", 32'(bus.out_b_valid), 1);
    rst_n = 1'b0;
    cyc();
    chk("mid_a_valid", 32'(bus.out_a_valid), 0);
    chk("mid_b_valid", 32'(bus.out_b_valid), 0);
    chk("mid_cnt_a", 32'(bus.cnt_a), 0);
    chk("mid_cnt_b", 32'(bus.cnt_b), 0);
    rst_n = 1'b1;
    bus.out_a_ready = 1'b1;
    bus.out_b_ready = 1'b1;
    cyc();
    cyc();
    chk("mid_no_stale_a", 32'(bus.out_a_valid), 0);
    chk("mid_no_stale_b", 32'(bus.out_b_valid), 0);
    chk("mid_post_cnt_a", 32'(bus.cnt_a), 0);

    chk("sb_a_drained", 32'(qa.size()), 0);
    chk("sb_b_drained", 32'(qb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/demux2_4_buf.md
DEMUX2_4_BUF -- requirements
Module: demux2_4_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data width of every data port.
REQ-002 The block SHALL have parameter DEPTH, default 2, number of entries per output buffer (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port in_data, input, WIDTH, word to route.
REQ-006 The block SHALL have port in_s, input, 1, destination select; 0 routes to channel A, 1 to channel B.
REQ-007 The block SHALL have port in_valid, input, 1, in_data/in_s are valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts the word this cycle.
REQ-009 The block SHALL have ports out_a_data and out_b_data, output, WIDTH, head word of channel A/B buffer.
REQ-010 The block SHALL have ports out_a_valid and out_b_valid, output, 1, the channel buffer is non-empty.
REQ-011 The block SHALL have ports out_a_ready and out_b_ready, input, 1, the consumer takes the head word this cycle.
REQ-012 The block SHALL have ports cnt_a and cnt_b, output, 8, count of words delivered on each channel.

Function
REQ-013 Input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; output transfer on channel X where out_x_valid and out_x_ready are both 1.
REQ-014 in_ready SHALL be combinational: 1 iff rst_n is 1 and the buffer selected by in_s holds fewer than DEPTH words; it SHALL NOT depend on the non-selected channel.
REQ-015 An accepted word SHALL be written only to the buffer selected by in_s in the same cycle; the other buffer SHALL be unaffected.
REQ-016 Latency: a word accepted at edge N into an empty buffer SHALL appear on out_x_data with out_x_valid=1 after edge N; no combinational path from in_data to out_x_data.
REQ-017 Each buffer SHALL be first-in first-out; read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 Simultaneous push and pop on the same channel SHALL leave the word count unchanged and preserve order; this includes the full case only when the pop is already granted, but in_ready SHALL still be 0 when full (no pass-through).
REQ-019 A pop on an empty buffer (out_x_ready=1, out_x_valid=0) SHALL have no effect.
REQ-020 out_x_valid SHALL be 1 iff the channel count is non-zero; out_x_data SHALL equal the head entry and hold stable while out_x_valid=1 and out_x_ready=0.
REQ-021 cnt_x SHALL increment by 1 on each channel-X output transfer and wrap from 255 to 0.
REQ-022 Both channels SHALL operate independently; push on A and pop on B in the same cycle SHALL both take effect.
REQ-023 Changes of in_s while in_valid=1 and in_ready=0 SHALL re-evaluate in_ready against the newly selected buffer in the same cycle.

Reset
REQ-024 On a rising edge with rst_n=0, all pointers and word counts SHALL clear to 0, cnt_a and cnt_b to 0, buffer storage to 0.
REQ-025 During reset, out_a_valid, out_b_valid and in_ready SHALL be 0 and out_a_data, out_b_data SHALL be 0 from the first reset edge.
REQ-026 Reset mid-operation SHALL discard buffered words; no transfer SHALL be counted on the reset edge.
REQ-027 After rst_n returns to 1, in_ready SHALL be 1 in the first cycle for either in_s value.

Structure
REQ-028 Package demux_pkg SHALL hold WIDTH_DEF=4, DEPTH_DEF=2, SEL_A=1'b0, SEL_B=1'b1 and the count width 8.
REQ-029 The per-channel buffer SHALL be one sub-module, fifo_buf (parameters WIDTH, DEPTH; push/pop, data, count, full/empty), instantiated twice.
REQ-030 Top level SHALL contain only select steering, the in_ready mux and the two delivery counters.

Verification
REQ-031 Reset: rst_n=0 for 2 edges with in_valid=1 -> all valid 0, in_ready 0, data 0, cnt 0; release -> in_ready=1.
REQ-032 Routing: push 0000 with s=0, then 1010 with s=1, consumers ready -> out_a_data=0000 and out_b_data=1010 each one edge after acceptance; cnt_a=1, cnt_b=1.
REQ-033 Full/backpressure: out_a_ready=0, push 1111,1100 with s=0 -> in_ready=0 on third attempt with s=0, in_ready=1 if s switched to 1; release -> A emits 1111 then 1100.
REQ-034 Simultaneous: A holds 1 word (0010), push 0011 to A while popping -> count stays 1, next head 0011.
REQ-035 Wrap: stream 300 words 0..F cyclic to B with out_b_ready=1 -> order preserved, cnt_b=44 (300 mod 256).
REQ-036 Mid-operation reset: A full, B one word, assert rst_n=0 one edge -> both empty, cnts 0, no stale word emitted after release.
